// File: rtl/bot_sync_pkg.sv
// Shared helpers for the multi-channel rojobot update synchroniser: width functions,
// default parameter values and the snapshot field layout.
package bot_sync_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Select width never collapses to zero, even for a single channel.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? clog2(n_ch) : 1;
  endfunction

  localparam int DEF_N_CH        = 2;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  localparam int CH_W  = ch_width(DEF_N_CH);
  localparam int PTR_W = clog2(DEF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Snapshot layout: {LocX, LocY, Sensors, BotInfo}
  localparam int LOCX_LSB = 24;
  localparam int LOCY_LSB = 16;
  localparam int SENS_LSB = 8;
  localparam int INFO_LSB = 0;

endpackage

// File: rtl/bot_upd_sync.sv
// Brings one asynchronous update strobe into the clk domain and turns each rising
// level into a single-cycle push pulse.
module bot_upd_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic upd_in,
  output logic push
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], upd_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  // edge_q clears on reset, so a level held through reset release still pushes once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign push = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/bot_update_sync_n.sv
// Per-channel strobe synchroniser, snapshot FIFO, sticky overflow and maskable irq.
// Define BOT_SYNC_OVERWRITE_EN to make a push to a full FIFO replace its oldest entry.
module bot_update_sync_n
  import bot_sync_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH-1:0]             upd_in,
  input  logic [N_CH*DATA_W-1:0]      bot_info,
  input  logic [ch_width(N_CH)-1:0]   ch_sel,
  input  logic                        rd_ack,
  input  logic [N_CH-1:0]             int_mask,
  input  logic [N_CH-1:0]             ovf_clr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic [clog2(DEPTH):0]       rd_count,
  output logic [N_CH-1:0]             pending,
  output logic [N_CH-1:0]             overflow,
  output logic                        irq
);

  localparam int SEL_W = ch_width(N_CH);
  localparam int P_W   = clog2(DEPTH);
  localparam int C_W   = P_W + 1;

  logic [DATA_W-1:0] head_data [N_CH];
  logic [C_W-1:0]    head_cnt  [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [P_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [P_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [C_W-1:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, full, empty;
    logic [DATA_W-1:0] wr_data;

    bot_upd_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .upd_in (upd_in[c]),
      .push   (push)
    );

    assign wr_data = bot_info[c*DATA_W +: DATA_W];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == C_W'(DEPTH));
    assign pop     = rd_ack && (ch_sel == SEL_W'(c)) && !empty;

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q & ~ovf_clr[c];

      // A pop in the same cycle frees a slot, so push-to-full plus pop is a plain push+pop.
      if (push && (!full || pop)) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      if (push && !pop && !full) cnt_d = cnt_q + 1'b1;
      if (pop && !push)          cnt_d = cnt_q - 1'b1;

      if (push && full && !pop) begin
        ovf_d = 1'b1;
`ifdef BOT_SYNC_OVERWRITE_EN
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
        rd_ptr_d        = rd_ptr_q + 1'b1;
`endif
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        ovf_q    <= ovf_d;
      end
    end

    // Storage needs no reset: empty FIFOs are masked to zero at the read mux.
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end

    assign head_data[c] = mem_q[rd_ptr_q];
    assign head_cnt[c]  = cnt_q;
    assign pending[c]   = !empty;
    assign overflow[c]  = ovf_q;
  end

  always_comb begin
    rd_data  = '0;
    rd_count = '0;
    if (int'(ch_sel) < N_CH) begin
      rd_count = head_cnt[ch_sel];
      if (head_cnt[ch_sel] != '0) rd_data = head_data[ch_sel];
    end
  end

  assign rd_valid = (rd_count != '0);

  logic irq_q, irq_d;

  always_comb begin
    irq_d = |(pending & ~int_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_bot_update_sync_n.sv
// Directed bench for bot_update_sync_n (3 channels, depth 4) with a queue-based model
// checked every cycle plus literal expectations at key points.
module tb_bot_update_sync_n;

  localparam int N_CH   = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int S      = 2;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 3;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N_CH-1:0]        upd_in   = '0;
  logic [N_CH*DATA_W-1:0] bot_info = '0;
  logic [SEL_W-1:0]       ch_sel   = '0;
  logic                   rd_ack   = 1'b0;
  logic [N_CH-1:0]        int_mask = '0;
  logic [N_CH-1:0]        ovf_clr  = '0;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid;
  logic [CNT_W-1:0]       rd_count;
  logic [N_CH-1:0]        pending;
  logic [N_CH-1:0]        overflow;
  logic                   irq;

  bot_update_sync_n #(
    .N_CH        (N_CH),
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .upd_in   (upd_in),
    .bot_info (bot_info),
    .ch_sel   (ch_sel),
    .rd_ack   (rd_ack),
    .int_mask (int_mask),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_count (rd_count),
    .pending  (pending),
    .overflow (overflow),
    .irq      (irq)
  );

  int vectors = 0;
  int errors  = 0;
  bit run_cmp = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per channel; a level seen rising on the sampled
  // input becomes a write S edges later.
  logic [DATA_W-1:0] mq [N_CH][$];
  logic [N_CH-1:0]   m_ovf = '0;
  logic              m_irq = 1'b0;
  logic [N_CH-1:0]   h [0:S];
  logic [N_CH-1:0]   m_pend, m_push;
  logic              m_pop;
  logic [DATA_W-1:0] m_wd;

  initial for (int i = 0; i <= S; i++) h[i] = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) mq[c].delete();
      m_ovf = '0;
      m_irq = 1'b0;
      for (int i = 0; i <= S; i++) h[i] = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) m_pend[c] = (mq[c].size() != 0);
      m_irq  = |(m_pend & ~int_mask);
      m_push = h[S-1] & ~h[S];
      for (int i = S; i > 0; i--) h[i] = h[i-1];
      h[0] = upd_in;
      for (int c = 0; c < N_CH; c++) begin
        m_pop = rd_ack && (int'(ch_sel) == c) && (mq[c].size() > 0);
        m_wd  = bot_info[c*DATA_W +: DATA_W];
        if (ovf_clr[c]) m_ovf[c] = 1'b0;
        if (m_push[c] && m_pop) begin
          void'(mq[c].pop_front());
          mq[c].push_back(m_wd);
        end else if (m_push[c]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(m_wd);
          else begin
            m_ovf[c] = 1'b1;
`ifdef BOT_SYNC_OVERWRITE_EN
            void'(mq[c].pop_front());
            mq[c].push_back(m_wd);
`endif
          end
        end else if (m_pop) begin
          void'(mq[c].pop_front());
        end
      end
    end
  end

  // Per-cycle compare, between input changes and the next active edge.
  task automatic compare_all();
    int sel;
    logic [DATA_W-1:0] e_data;
    logic [CNT_W-1:0]  e_cnt;
    logic [N_CH-1:0]   e_pend;
    sel    = int'(ch_sel);
    e_data = '0;
    e_cnt  = '0;
    if (sel < N_CH) begin
      e_cnt = CNT_W'(mq[sel].size());
      if (mq[sel].size() > 0) e_data = mq[sel][0];
    end
    for (int c = 0; c < N_CH; c++) e_pend[c] = (mq[c].size() != 0);
    chk("cyc_rd_data",  64'(rd_data),  64'(e_data));
    chk("cyc_rd_count", 64'(rd_count), 64'(e_cnt));
    chk("cyc_rd_valid", 64'(rd_valid), 64'(e_cnt != 0));
    chk("cyc_pending",  64'(pending),  64'(e_pend));
    chk("cyc_overflow", 64'(overflow), 64'(m_ovf));
    chk("cyc_irq",      64'(irq),      64'(m_irq));
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      #3;
      compare_all();
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input int c, input logic [DATA_W-1:0] d);
    bot_info[c*DATA_W +: DATA_W] = d;
    upd_in[c] = 1'b1;
    tick(3);
    upd_in[c] = 1'b0;
    tick(3);
  endtask

  task automatic pop_ch(input int c);
    ch_sel = SEL_W'(c);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  int hold [N_CH];

  initial begin
    tick(2);
    reset = 1'b0;
    tick(2);

    // single push on channel 0
    bot_info[31:0] = 32'h1020_0304;
    upd_in[0] = 1'b1;
    tick(2);
    chk("t1_pending_early", 64'(pending), 64'h0);
    tick(1);
    chk("t1_pending", 64'(pending), 64'h1);
    chk("t1_irq_early", 64'(irq), 64'h0);
    tick(1);
    chk("t1_irq", 64'(irq), 64'h1);
    upd_in[0] = 1'b0;
    ch_sel = 2'd0;
    #1;
    chk("t1_rd_data", 64'(rd_data), 64'h1020_0304);
    chk("t1_rd_count", 64'(rd_count), 64'h1);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("t1_pending_pop", 64'(pending), 64'h0);
    chk("t1_irq_hold", 64'(irq), 64'h1);
    tick(1);
    chk("t1_irq_drop", 64'(irq), 64'h0);
    tick(2);

    // overflow on channel 1
    for (int i = 1; i <= 5; i++) push_pulse(1, DATA_W'(i));
    tick(2);
    ch_sel = 2'd1;
    #1;
    chk("t2_overflow", 64'(overflow), 64'h2);
    chk("t2_rd_count", 64'(rd_count), 64'h4);
    for (int i = 0; i < 4; i++) begin
`ifdef BOT_SYNC_OVERWRITE_EN
      chk("t2_pop_data", 64'(rd_data), 64'(i + 2));
`else
      chk("t2_pop_data", 64'(rd_data), 64'(i + 1));
`endif
      pop_ch(1);
    end
    chk("t2_empty", 64'(rd_count), 64'h0);
    ovf_clr = 3'b010;
    tick(1);
    ovf_clr = '0;
    chk("t2_ovf_clr", 64'(overflow), 64'h0);

    // push and pop on the same edge
    ch_sel = 2'd0;
    bot_info[31:0] = 32'hAAAA_0001;
    upd_in[0] = 1'b1;
    tick(2);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("t3_empty_cnt", 64'(rd_count), 64'h1);
    chk("t3_empty_data", 64'(rd_data), 64'hAAAA_0001);
    upd_in[0] = 1'b0;
    tick(3);
    push_pulse(0, 32'hBBBB_0002);
    bot_info[31:0] = 32'hCCCC_0003;
    upd_in[0] = 1'b1;
    tick(2);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    chk("t3_two_cnt", 64'(rd_count), 64'h2);
    chk("t3_two_head", 64'(rd_data), 64'hBBBB_0002);
    upd_in[0] = 1'b0;
    tick(3);
    pop_ch(0);
    chk("t3_last", 64'(rd_data), 64'hCCCC_0003);
    pop_ch(0);

    // simultaneous pushes, masking, out-of-range select
    int_mask = 3'b001;
    bot_info[31:0]  = 32'hA0A0_A0A0;
    bot_info[63:32] = 32'hB0B0_B0B0;
    upd_in = 3'b011;
    tick(3);
    chk("t4_pending", 64'(pending), 64'h3);
    tick(1);
    chk("t4_irq", 64'(irq), 64'h1);
    upd_in = '0;
    ch_sel = 2'd3;
    #1;
    chk("t4_oor_valid", 64'(rd_valid), 64'h0);
    chk("t4_oor_data", 64'(rd_data), 64'h0);
    ch_sel = 2'd2;
    #1;
    chk("t4_ch2_valid", 64'(rd_valid), 64'h0);
    ch_sel = 2'd1;
    #1;
    chk("t4_ch1_data", 64'(rd_data), 64'hB0B0_B0B0);
    pop_ch(1);
    chk("t4_pending1", 64'(pending), 64'h1);
    tick(1);
    chk("t4_irq_masked", 64'(irq), 64'h0);
    int_mask = '0;
    tick(1);
    chk("t4_irq_unmask", 64'(irq), 64'h1);
    int_mask = 3'b001;
    tick(1);
    chk("t4_irq_mask", 64'(irq), 64'h0);
    pop_ch(0);
    int_mask = '0;
    tick(2);

    // reset while busy, with the strobe held across release
    push_pulse(0, 32'h51);
    push_pulse(0, 32'h52);
    push_pulse(0, 32'h53);
    ch_sel = 2'd0;
    bot_info[31:0] = 32'h5555;
    upd_in[0] = 1'b1;
    tick(1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_pending", 64'(pending), 64'h0);
    chk("t5_irq", 64'(irq), 64'h0);
    chk("t5_rd_valid", 64'(rd_valid), 64'h0);
    chk("t5_rd_count", 64'(rd_count), 64'h0);
    chk("t5_rd_data", 64'(rd_data), 64'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("t5_one_push", 64'(rd_count), 64'h1);
    chk("t5_data", 64'(rd_data), 64'h5555);
    upd_in[0] = 1'b0;
    tick(3);
    pop_ch(0);
    tick(5);
    chk("t5_no_more", 64'(rd_count), 64'h0);

    // long held level
    bot_info[95:64] = 32'h66;
    upd_in[2] = 1'b1;
    tick(100);
    ch_sel = 2'd2;
    #1;
    chk("t6_held_one", 64'(rd_count), 64'h1);
    upd_in[2] = 1'b0;
    tick(3);
    pop_ch(2);

    // random pulse spacing, pops and clears against the model
    for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(3, 8);
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hold[c] == 0) begin
          if (!upd_in[c]) bot_info[c*DATA_W +: DATA_W] = $urandom;
          upd_in[c] = ~upd_in[c];
          hold[c]   = $urandom_range(3, 8);
        end else begin
          hold[c]--;
        end
      end
      rd_ack  = ($urandom_range(0, 2) == 0);
      ch_sel  = SEL_W'($urandom_range(0, 3));
      ovf_clr = ($urandom_range(0, 15) == 0) ? N_CH'($urandom_range(0, 7)) : '0;
      if ($urandom_range(0, 19) == 0) int_mask = N_CH'($urandom_range(0, 7));
      tick(1);
    end
    upd_in  = '0;
    rd_ack  = 1'b0;
    ovf_clr = '0;
    tick(6);

    run_cmp = 1'b0;
    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
